// File: rtl/dac_spi_tx.sv
// dac_spi_tx: write-only SPI master that frames one command word to the MAX5134 DAC, MSB first
module dac_spi_tx #(
    parameter int DATA_WIDTH  = 24,
    parameter int HALF_PERIOD = 2
) (
    input  logic                  clock_in,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  send,
    output logic                  spi_cs_out,
    output logic                  spi_clock_out,
    output logic                  spi_data_out,
    output logic                  busy
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int HW = $clog2(HALF_PERIOD + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BW-1:0]         r_bits;
    logic [HW-1:0]         r_half;
    logic                  r_sclk;
    logic                  w_tick;
    logic                  w_accept;
    logic                  w_end;

    assign w_tick   = r_half == HW'(HALF_PERIOD - 1);
    assign w_accept = send && (r_state == IDLE || (r_state == HOLD && w_tick));
    assign w_end    = r_state == SHIFT && w_tick && !r_sclk && r_bits == BW'(DATA_WIDTH);

    assign spi_cs_out    = r_state != SHIFT;
    assign busy          = r_state != IDLE;
    assign spi_clock_out = r_sclk;
    assign spi_data_out  = r_shift[DATA_WIDTH-1];

    // state register
    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next state: a send at the end of HOLD starts the next frame without an idle cycle
    always_comb begin
        w_next = r_state;
        w_next = w_accept ? SHIFT :
                 w_end ? HOLD :
                 (r_state == HOLD && w_tick) ? IDLE : r_state;
    end

    // half-period timer, SCLK generation, bit counting and MSB-first shifting
    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn) begin
            r_shift <= '0;
            r_bits  <= '0;
            r_half  <= '0;
            r_sclk  <= 1'b0;
        end else if (w_accept) begin
            r_shift <= data_in;
            r_bits  <= '0;
            r_half  <= '0;
            r_sclk  <= 1'b0;
        end else if (r_state != IDLE) begin
            r_half <= w_tick ? '0 : r_half + HW'(1);
            if (r_state == SHIFT && w_tick) begin
                if (r_sclk) begin
                    r_sclk <= 1'b0;
                    r_bits <= r_bits + BW'(1);
                end else if (r_bits != BW'(DATA_WIDTH)) begin
                    r_sclk <= 1'b1;
                    if (r_bits != '0) r_shift <= r_shift << 1;
                end else begin
                    r_shift <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: scoreboard bench for dac_spi_tx at default size plus an 8-bit, H=1 instance
module tb_dac_spi_tx;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [23:0] a_data = '0;
    logic        a_send = 1'b0;
    logic        a_cs, a_sclk, a_dout, a_busy;
    logic [7:0]  b_data = '0;
    logic        b_send = 1'b0;
    logic        b_cs, b_sclk, b_dout, b_busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [23:0] exp_q[$];

    dac_spi_tx dut_a (
        .clock_in(clk), .rstn(rstn), .data_in(a_data), .send(a_send),
        .spi_cs_out(a_cs), .spi_clock_out(a_sclk), .spi_data_out(a_dout), .busy(a_busy)
    );

    dac_spi_tx #(.DATA_WIDTH(8), .HALF_PERIOD(1)) dut_b (
        .clock_in(clk), .rstn(rstn), .data_in(b_data), .send(b_send),
        .spi_cs_out(b_cs), .spi_clock_out(b_sclk), .spi_data_out(b_dout), .busy(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // frame monitor for the default instance: reassembles words on SCLK falls and times CS/busy
    logic [23:0] m_word = '0;
    int          m_np = 0, m_cs_lo = 0, m_cs_hi = 0, m_busy = 0, m_frames = 0, m_fall = 0;
    logic        m_hi = 1'b0, p_sclk = 1'b0, p_cs = 1'b1, p_busy = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            m_word = '0; m_np = 0; m_cs_lo = 0; m_cs_hi = 0; m_busy = 0; m_frames = 0;
            p_sclk = 1'b0; p_cs = 1'b1; p_busy = 1'b0;
        end else begin
            if (a_cs && a_busy) m_cs_hi++;
            if (!a_cs) m_cs_lo++;
            if (a_busy) m_busy++;
            if (a_sclk && !p_sclk) m_hi = a_dout;
            if (!a_sclk && p_sclk) begin
                chk("din_hold", 32'(a_dout), 32'(m_hi));
                m_word = {m_word[22:0], a_dout};
                m_np++;
            end
            if (!a_cs && p_cs) begin
                if (m_frames > 0) begin
                    chk("frame_period", cyc - m_fall, 100);
                    chk("cs_gap", m_cs_hi, 2);
                end
                m_fall = cyc; m_cs_hi = 0; m_cs_lo = 1; m_word = '0; m_np = 0;
            end
            if (a_cs && !p_cs) begin
                if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
                else chk("word", 32'(m_word), 32'(exp_q.pop_front()));
                chk("pulses", m_np, 24);
                chk("cs_low", m_cs_lo, 98);
                m_cs_lo = 0;
                m_frames++;
            end
            if (!a_busy && p_busy) begin
                chk("busy_len", m_busy, 100 * m_frames);
                m_busy = 0; m_frames = 0;
            end
            p_sclk = a_sclk; p_cs = a_cs; p_busy = a_busy;
        end
    end

    task automatic send_a(input logic [23:0] d);
        @(negedge clk);
        a_data = d;
        a_send = 1'b1;
        exp_q.push_back(d);
        @(negedge clk);
        a_send = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!a_busy && exp_q.size() == 0) break;
        end
        repeat (2) @(negedge clk);
        chk("idle_timeout", {31'd0, a_busy}, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] bw;
        int bp, bfall, bbad;
        logic bprev;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        // idle with send low
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle", {28'd0, a_cs, a_sclk, a_dout, a_busy}, 32'b1000);
        end
        // single frame
        send_a(24'h31A5F0);
        wait_idle();
        // data_in changes after acceptance
        send_a(24'h000000);
        a_data = 24'hFFFFFF;
        wait_idle();
        // send pulse mid-frame is ignored
        send_a(24'hC3_5A_81);
        repeat (8) @(negedge clk);
        a_send = 1'b1;
        @(negedge clk);
        a_send = 1'b0;
        wait_idle();
        // send held high: three back-to-back frames
        @(negedge clk);
        a_data = 24'h31_7E_01;
        a_send = 1'b1;
        repeat (3) exp_q.push_back(24'h31_7E_01);
        repeat (250) @(negedge clk);
        a_send = 1'b0;
        wait_idle();
        // reset after the 12th falling edge
        @(negedge clk);
        a_data = 24'h31_12_34;
        a_send = 1'b1;
        @(negedge clk);
        a_send = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (m_np == 12) break;
        end
        chk("reached_pulse12", m_np, 12);
        rstn = 1'b0;
        #1;
        chk("reset_outputs", {28'd0, a_cs, a_sclk, a_dout, a_busy}, 32'b1000);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        send_a(24'h3100FF);
        wait_idle();
        // narrow instance: 8 bits, H=1
        @(negedge clk);
        b_data = 8'hA5;
        b_send = 1'b1;
        @(posedge clk);
        #1;
        b_send = 1'b0;
        chk("b_accept", {30'd0, b_cs, b_busy}, 32'b01);
        bw = '0; bp = 0; bfall = 0; bbad = 0; bprev = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (!b_sclk && bprev) begin
                bw = {bw[6:0], b_dout};
                bp++;
                if (k != 2 * bp) bbad++;
            end
            if (!b_busy && bfall == 0) bfall = k;
            bprev = b_sclk;
        end
        chk("b_pulses", bp, 8);
        chk("b_pulse_timing", bbad, 0);
        chk("b_word", 32'(bw), 32'hA5);
        chk("b_busy_fall", bfall, 18);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
